// File: rtl/modem_tx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modem_tx_pkg : tap codes, stage count, sequencer states, dibit->code map
// Revision 1.0
// ---------------------------------------------------------------------------
package modem_tx_pkg;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b11;

  localparam int NUM_STAGES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [1:0] q;
    logic [1:0] i;
  } tap_pair_t;

  // Sign bit 0 is +coefficient, 1 is -coefficient.
  function automatic tap_pair_t dibit_to_codes(input logic [1:0] dibit);
    tap_pair_t p;
    p.i = dibit[0] ? CODE_NEG : CODE_POS;
    p.q = dibit[1] ? CODE_NEG : CODE_POS;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_tap_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_tap_line : 2-bit-per-symbol delay line, newest code at [1:0]
// Revision 1.0
// ---------------------------------------------------------------------------
module tx_tap_line
  import modem_tx_pkg::*;
#(
  parameter int TAPS = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [1:0]        code_in,
  output logic [2*TAPS-1:0] taps
);

  logic [2*TAPS-1:0] taps_q;
  logic [2*TAPS-1:0] taps_d;
  logic [2*TAPS-1:0] shifted;

  generate
    if (TAPS > 1) begin : g_multi
      assign shifted = {taps_q[2*TAPS-3:0], code_in};
    end else begin : g_single
      assign shifted = code_in;
    end
  endgenerate

  always_comb begin
    taps_d = taps_q;
    if (clear) begin
      taps_d = {TAPS{CODE_ZERO}};
    end else if (shift_en) begin
      taps_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule
`default_nettype wire

// File: rtl/tx_symbol_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_symbol_feeder : QPSK symbol sequencer for the polyphase shaping filter
// Revision 1.0
// ---------------------------------------------------------------------------
module tx_symbol_feeder
  import modem_tx_pkg::*;
#(
  parameter int DIV  = 4,
  parameter int TAPS = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [1:0]        sym_data,
  input  logic              sym_last,
  output logic [2:0]        stage,
  output logic              enable,
  output logic [2*TAPS-1:0] taps_i,
  output logic [2*TAPS-1:0] taps_q,
  output logic              busy,
  output logic              underflow
);

  localparam int             CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int             DW         = $clog2(TAPS + 1);
  localparam logic [CW-1:0]  CNT_MAX    = CW'(DIV - 1);
  localparam logic [DW-1:0]  DRAIN_MAX  = DW'(TAPS);
  localparam logic [2:0]     LAST_STAGE = 3'(NUM_STAGES - 1);

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     stage_q, stage_d;
  logic           enable_q, enable_d;
  logic           busy_q, busy_d;
  logic           underflow_q, underflow_d;
  logic           full_q, full_d;
  logic [1:0]     hold_data_q, hold_data_d;
  logic           hold_last_q, hold_last_d;
  logic           shifted_last_q, shifted_last_d;
  logic [DW-1:0]  drain_cnt_q, drain_cnt_d;

  logic      accept;
  logic      stage_end;
  logic      shift_held;
  logic      shift_zero;
  logic      shift_en;
  logic      clear_lines;
  tap_pair_t codes;
  logic [1:0] code_i;
  logic [1:0] code_q;

  assign accept    = sym_valid && !full_q;
  assign stage_end = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stage_d        = stage_q;
    full_d         = full_q;
    hold_data_d    = hold_data_q;
    hold_last_d    = hold_last_q;
    shifted_last_d = shifted_last_q;
    drain_cnt_d    = drain_cnt_q;
    underflow_d    = 1'b0;
    shift_held     = 1'b0;
    shift_zero     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        stage_d = '0;
        if (full_q) begin
          state_d    = ST_RUN;
          shift_held = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (stage_end) begin
          cnt_d   = '0;
          stage_d = stage_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        // Symbol boundary: the only place the delay lines may move.
        if (stage_end && (stage_q == LAST_STAGE)) begin
          if (full_q) begin
            shift_held  = 1'b1;
            state_d     = ST_RUN;
            drain_cnt_d = '0;
          end else if (state_q == ST_RUN) begin
            shift_zero  = 1'b1;
            state_d     = ST_DRAIN;
            drain_cnt_d = DW'(1);
            underflow_d = !shifted_last_q;
          end else if (drain_cnt_q == DRAIN_MAX) begin
            state_d = ST_IDLE;
          end else begin
            shift_zero  = 1'b1;
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        stage_d = '0;
      end
    endcase

    if (shift_held) begin
      full_d         = 1'b0;
      shifted_last_d = hold_last_q;
    end
    // accept needs full_q==0 and shift_held needs full_q==1, so they never collide.
    if (accept) begin
      full_d      = 1'b1;
      hold_data_d = sym_data;
      hold_last_d = sym_last;
    end

    enable_d = (state_d != ST_IDLE) && (cnt_d == CNT_MAX);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      stage_q        <= '0;
      enable_q       <= 1'b0;
      busy_q         <= 1'b0;
      underflow_q    <= 1'b0;
      full_q         <= 1'b0;
      hold_data_q    <= '0;
      hold_last_q    <= 1'b0;
      shifted_last_q <= 1'b0;
      drain_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stage_q        <= stage_d;
      enable_q       <= enable_d;
      busy_q         <= busy_d;
      underflow_q    <= underflow_d;
      full_q         <= full_d;
      hold_data_q    <= hold_data_d;
      hold_last_q    <= hold_last_d;
      shifted_last_q <= shifted_last_d;
      drain_cnt_q    <= drain_cnt_d;
    end
  end

  assign codes       = dibit_to_codes(hold_data_q);
  assign code_i      = shift_held ? codes.i : CODE_ZERO;
  assign code_q      = shift_held ? codes.q : CODE_ZERO;
  assign shift_en    = shift_held || shift_zero;
  assign clear_lines = (state_q == ST_IDLE) && !full_q;

  tx_tap_line #(.TAPS(TAPS)) u_line_i (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clear    (clear_lines),
    .code_in  (code_i),
    .taps     (taps_i)
  );

  tx_tap_line #(.TAPS(TAPS)) u_line_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clear    (clear_lines),
    .code_in  (code_q),
    .taps     (taps_q)
  );

  assign sym_ready = !full_q;
  assign stage     = stage_q;
  assign enable    = enable_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_symbol_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_symbol_feeder : directed bench with expected-symbol scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_tx_symbol_feeder;

  localparam int DIV     = 4;
  localparam int TAPS    = 17;
  localparam int TW      = 2 * TAPS;
  localparam int SYM_CYC = 8 * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sym_valid = 1'b0;
  logic          sym_ready;
  logic [1:0]    sym_data = 2'b00;
  logic          sym_last = 1'b0;
  logic [2:0]    stage;
  logic          enable;
  logic [TW-1:0] taps_i;
  logic [TW-1:0] taps_q;
  logic          busy;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int uf_count = 0;
  int last_acc_cyc = 0;
  int prev_acc = 0;
  int a0 = 0;
  int u0 = 0;
  int uf0 = 0;

  logic [3:0] exp_q[$];

  logic          prev_busy = 1'b0;
  logic          prev_enable = 1'b0;
  logic [2:0]    prev_stage = 3'd0;
  logic [TW-1:0] prev_ti = '0;
  logic [TW-1:0] prev_tq = '0;
  logic          shift_ev;
  logic [2:0]    nxt_stage;
  logic [3:0]    got;

  tx_symbol_feeder #(.DIV(DIV), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .sym_last  (sym_last),
    .stage     (stage),
    .enable    (enable),
    .taps_i    (taps_i),
    .taps_q    (taps_q),
    .busy      (busy),
    .underflow (underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Independent model of the code map: {q_code, i_code}.
  function automatic logic [3:0] exp_codes(input logic [1:0] d);
    logic [1:0] ci;
    logic [1:0] cq;
    ci = d[0] ? 2'b11 : 2'b01;
    cq = d[1] ? 2'b11 : 2'b01;
    return {cq, ci};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic l);
    int t = 0;
    sym_data  = d;
    sym_last  = l;
    sym_valid = 1'b1;
    @(negedge clk);
    while (!sym_ready && t < 4 * TAPS * SYM_CYC) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", 64'(sym_ready), 64'(1));
    exp_q.push_back(exp_codes(d));
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
  endtask

  // Shift/stage monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy   = 1'b0;
      prev_enable = 1'b0;
      prev_stage  = 3'd0;
      prev_ti     = '0;
      prev_tq     = '0;
    end else begin
      if (underflow) uf_count++;
      if (busy) begin
        shift_ev  = !prev_busy || (prev_enable && prev_stage == 3'd7);
        nxt_stage = prev_stage + 3'd1;
        if (prev_busy)
          check("stage_step", 64'(stage), 64'(prev_enable ? nxt_stage : prev_stage));
        if (shift_ev) begin
          check("shift_i", 64'(taps_i[TW-1:2]), 64'(prev_ti[TW-3:0]));
          check("shift_q", 64'(taps_q[TW-1:2]), 64'(prev_tq[TW-3:0]));
          if (taps_i[1:0] != 2'b00 || taps_q[1:0] != 2'b00) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected", 64'(exp_q.size()), 64'(1));
            end else begin
              got = exp_q.pop_front();
              check("sb_symbol", 64'({taps_q[1:0], taps_i[1:0]}), 64'(got));
            end
          end
        end else if (prev_busy) begin
          check("taps_hold_i", 64'(taps_i), 64'(prev_ti));
          check("taps_hold_q", 64'(taps_q), 64'(prev_tq));
        end
      end
      prev_busy   = busy;
      prev_enable = enable;
      prev_stage  = stage;
      prev_ti     = taps_i;
      prev_tq     = taps_q;
    end
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stage", 64'(stage), 64'(0));
    check("rst_enable", 64'(enable), 64'(0));
    check("rst_taps_i", 64'(taps_i), 64'(0));
    check("rst_taps_q", 64'(taps_q), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));
    check("rst_ready", 64'(sym_ready), 64'(1));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cycles(1);
      check("idle_enable", 64'(enable), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
    end

    // Single symbol, last of burst
    uf0 = uf_count;
    send(2'b10, 1'b1);
    sym_valid = 1'b0;
    wait_cycles(1);
    check("single_taps_i", 64'(taps_i), 64'h1);
    check("single_taps_q", 64'(taps_q), 64'h3);
    check("single_busy", 64'(busy), 64'(1));
    check("single_stage0", 64'(stage), 64'(0));
    check("single_enable0", 64'(enable), 64'(0));
    for (int k = 1; k <= 18 * SYM_CYC; k++) begin
      wait_cycles(1);
      if (k < SYM_CYC) begin
        check("single_enable", 64'(enable), 64'((k % DIV) == (DIV - 1)));
        check("single_stage", 64'(stage), 64'(k / DIV));
      end
      if (k == SYM_CYC) begin
        check("single_shift_i", 64'(taps_i), 64'h4);
        check("single_shift_q", 64'(taps_q), 64'hC);
      end
      if (k == 18 * SYM_CYC - 1) check("single_busy_tail", 64'(busy), 64'(1));
      if (k == 18 * SYM_CYC) check("single_busy_fall", 64'(busy), 64'(0));
    end
    check("single_no_uf", 64'(uf_count - uf0), 64'(0));

    // Continuous stream of 20 symbols
    uf0 = uf_count;
    for (int i = 0; i < 20; i++) begin
      send(2'(i * 3), i == 19);
      if (i >= 2) check("stream_interval", 64'(last_acc_cyc - prev_acc), 64'(SYM_CYC));
      prev_acc = last_acc_cyc;
    end
    sym_valid = 1'b0;
    for (int i = 0; i < (TAPS + 3) * SYM_CYC && busy; i++) wait_cycles(1);
    check("stream_idle", 64'(busy), 64'(0));
    check("stream_no_uf", 64'(uf_count - uf0), 64'(0));
    check("stream_sb_empty", 64'(exp_q.size()), 64'(0));

    // Underflow: two non-last symbols then nothing
    send(2'b01, 1'b0);
    a0 = last_acc_cyc;
    send(2'b11, 1'b0);
    sym_valid = 1'b0;
    for (int i = 0; i < 4 * SYM_CYC && !underflow; i++) wait_cycles(1);
    check("uf_pulse", 64'(underflow), 64'(1));
    check("uf_time", 64'(cyc - a0), 64'(1 + 2 * SYM_CYC));
    u0 = cyc;
    check("uf_taps_i", 64'(taps_i), 64'h3C);
    check("uf_taps_q", 64'(taps_q), 64'h1C);
    check("uf_busy", 64'(busy), 64'(1));
    wait_cycles(1);
    check("uf_one_cycle", 64'(underflow), 64'(0));

    // Resume: offer a symbol after the fifth drain boundary
    uf0 = uf_count;
    wait_cycles(129);
    send(2'b00, 1'b1);
    sym_valid = 1'b0;
    check("resume_accept", 64'(last_acc_cyc - u0), 64'(131));
    wait_cycles(u0 + 159 - cyc);
    check("resume_pre_i", 64'(taps_i), 64'h3C00);
    wait_cycles(1);
    check("resume_taps_i", 64'(taps_i), 64'hF001);
    check("resume_taps_q", 64'(taps_q), 64'h7001);
    check("resume_stage", 64'(stage), 64'(0));
    check("resume_busy", 64'(busy), 64'(1));
    wait_cycles(18 * SYM_CYC - 1);
    check("resume_busy_tail", 64'(busy), 64'(1));
    wait_cycles(1);
    check("resume_busy_fall", 64'(busy), 64'(0));
    check("resume_no_uf", 64'(uf_count - uf0), 64'(0));

    // Reset mid-burst with a held symbol
    send(2'b00, 1'b1);
    send(2'b11, 1'b1);
    sym_valid = 1'b0;
    for (int i = 0; i < SYM_CYC && stage != 3'd5; i++) wait_cycles(1);
    check("mid_stage5", 64'(stage), 64'(5));
    check("mid_full", 64'(sym_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("mid_taps_i", 64'(taps_i), 64'(0));
    check("mid_taps_q", 64'(taps_q), 64'(0));
    check("mid_stage", 64'(stage), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_enable", 64'(enable), 64'(0));
    check("mid_ready", 64'(sym_ready), 64'(1));
    exp_q.delete();
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(3 * SYM_CYC);
    check("mid_post_busy", 64'(busy), 64'(0));
    check("mid_post_taps", 64'(taps_i), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
